// File: rtl/cva6_spm_resp_pkg.sv
// cva6_spm_resp_pkg: request/response types, stage and reservation structs for the SPM responder
package cva6_spm_resp_pkg;

    localparam int SPM_WORD_BITS = 64;

    typedef enum logic [3:0] {
        OP_LOAD,
        OP_STORE,
        OP_AMO_LR,
        OP_AMO_SC,
        OP_AMO_SWAP,
        OP_AMO_ADD,
        OP_AMO_AND,
        OP_AMO_OR,
        OP_AMO_XOR,
        OP_AMO_MAX,
        OP_AMO_MAXU,
        OP_AMO_MIN,
        OP_AMO_MINU
    } hpdcache_req_op_t;

    typedef logic [51:0] hpdcache_tag_t;

    typedef struct packed {
        hpdcache_req_op_t           op;
        logic [11:0]                addr_offset;
        hpdcache_tag_t              addr_tag;
        logic [SPM_WORD_BITS-1:0]   wdata;
        logic [7:0]                 be;
        logic [1:0]                 size;
        logic [2:0]                 sid;
        logic [7:0]                 tid;
        logic                       need_rsp;
        logic                       phys_indexed;
    } hpdcache_req_t;

    typedef struct packed {
        logic uncacheable;
        logic io;
    } hpdcache_pma_t;

    typedef struct packed {
        logic [SPM_WORD_BITS-1:0] rdata;
        logic [2:0]               sid;
        logic [7:0]               tid;
        logic                     error;
        logic                     aborted;
    } hpdcache_rsp_t;

    typedef enum logic {IDLE, AMO_RMW} state_t;

    typedef struct packed {
        logic          valid;
        hpdcache_req_t req;
    } s1_t;

    typedef struct packed {
        logic        valid;
        logic [60:0] granule;
    } resv_t;

    // LR, SC and all read-modify-write atomics
    function automatic logic is_amo(hpdcache_req_op_t op);
        return op >= OP_AMO_LR;
    endfunction

    // Atomics that need the two-cycle read-modify-write sequence
    function automatic logic is_rmw(hpdcache_req_op_t op);
        return op >= OP_AMO_SWAP;
    endfunction

endpackage

// File: rtl/cva6_spm_amo_alu.sv
// cva6_spm_amo_alu: combinational AMO datapath producing the new 64-bit word from old word and operand
module cva6_spm_amo_alu
    import cva6_spm_resp_pkg::*;
(
    input  hpdcache_req_op_t i_op,
    input  logic [1:0]       i_size,
    input  logic [7:0]       i_be,
    input  logic [63:0]      i_old,
    input  logic [63:0]      i_operand,
    output logic [63:0]      o_new
);

    logic        w_w32;
    logic        w_hi;
    logic [63:0] w_a;
    logic [63:0] w_b;
    logic [63:0] w_r;
    logic        w_unused;

    // 32-bit lanes are sign-extended so one 64-bit comparator serves signed and unsigned forms
    assign w_w32 = i_size == 2'b10;
    assign w_hi  = i_be[4];
    assign w_a   = ~w_w32 ? i_old : w_hi ? {{32{i_old[63]}}, i_old[63:32]} : {{32{i_old[31]}}, i_old[31:0]};
    assign w_b   = ~w_w32 ? i_operand : w_hi ? {{32{i_operand[63]}}, i_operand[63:32]} : {{32{i_operand[31]}}, i_operand[31:0]};
    assign w_unused = ^{i_be[7:5], i_be[3:0]};

    // Operation select
    always_comb begin
        w_r = w_a;
        case (i_op)
            OP_AMO_SWAP: w_r = w_b;
            OP_AMO_ADD:  w_r = w_a + w_b;
            OP_AMO_AND:  w_r = w_a & w_b;
            OP_AMO_OR:   w_r = w_a | w_b;
            OP_AMO_XOR:  w_r = w_a ^ w_b;
            OP_AMO_MAX:  w_r = $signed(w_a) > $signed(w_b) ? w_a : w_b;
            OP_AMO_MAXU: w_r = w_a > w_b ? w_a : w_b;
            OP_AMO_MIN:  w_r = $signed(w_a) < $signed(w_b) ? w_a : w_b;
            OP_AMO_MINU: w_r = w_a < w_b ? w_a : w_b;
            default:     w_r = w_a;
        endcase
    end

    assign o_new = ~w_w32 ? w_r : w_hi ? {w_r[31:0], i_old[31:0]} : {i_old[63:32], w_r[31:0]};

endmodule

// File: rtl/cva6_hpdcache_spm_responder.sv
// cva6_hpdcache_spm_responder: 64-bit-word SPM terminating HPDcache req/rsp; AMO/LR/SC enabled by CVA6_SPM_RESP_AMO_EN
module cva6_hpdcache_spm_responder
    import cva6_spm_resp_pkg::*;
#(
    parameter logic [63:0] SPM_BASE  = 64'h0000_0000_1000_0000,
    parameter int unsigned SPM_WORDS = 512
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  hpdcache_req_t req_i,
    input  logic          req_abort_i,
    input  hpdcache_tag_t req_tag_i,
    input  hpdcache_pma_t req_pma_i,
    output logic          rsp_valid_o,
    output hpdcache_rsp_t rsp_o
);

`ifdef CVA6_SPM_RESP_AMO_EN
    localparam bit AMO_EN = 1'b1;
`else
    localparam bit AMO_EN = 1'b0;
`endif
    localparam int          IW        = $clog2(SPM_WORDS);
    localparam logic [63:0] SPM_BYTES = 64'(SPM_WORDS) << 3;

    logic [63:0]   r_mem [SPM_WORDS];
    s1_t           r_s1;
    state_t        r_state;
    resv_t         r_resv;
    logic [IW-1:0] r_amo_idx;
    logic [63:0]   r_amo_old;
    logic          r_rsp_valid;
    hpdcache_rsp_t r_rsp;

    logic [63:0]   w_addr;
    logic [63:0]   w_off;
    logic [63:0]   w_old;
    logic [63:0]   w_merge;
    logic [63:0]   w_amo_new;
    logic [63:0]   w_wdata;
    logic [IW-1:0] w_idx;
    logic [IW-1:0] w_widx;
    logic          w_abort;
    logic          w_inwin;
    logic          w_ok;
    logic          w_hit;
    logic          w_is_load;
    logic          w_is_store;
    logic          w_is_lr;
    logic          w_is_sc;
    logic          w_is_rmw;
    logic          w_feat_err;
    logic          w_go_rmw;
    logic          w_in_rmw;
    logic          w_we;
    logic          w_s1_rsp;
    logic          w_accept;
    hpdcache_rsp_t w_rsp;
    logic          w_unused;

    // Late tag completes the address of virtually-indexed requests in S1
    assign w_addr  = {r_s1.req.phys_indexed ? r_s1.req.addr_tag : req_tag_i, r_s1.req.addr_offset};
    assign w_off   = w_addr - SPM_BASE;
    assign w_inwin = (w_addr >= SPM_BASE) && (w_off < SPM_BYTES);
    assign w_idx   = w_off[IW+2:3];
    assign w_abort = ~r_s1.req.phys_indexed & req_abort_i;
    assign w_ok    = w_inwin & ~w_abort;
    assign w_old   = r_mem[w_idx];
    assign w_hit   = r_resv.valid && (r_resv.granule == w_addr[63:3]);

    assign w_is_load  = r_s1.req.op == OP_LOAD;
    assign w_is_store = r_s1.req.op == OP_STORE;
    assign w_is_lr    = r_s1.req.op == OP_AMO_LR;
    assign w_is_sc    = r_s1.req.op == OP_AMO_SC;
    assign w_is_rmw   = is_rmw(r_s1.req.op);
    assign w_feat_err = is_amo(r_s1.req.op) & ~AMO_EN;
    assign w_go_rmw   = r_s1.valid & w_is_rmw & w_ok & AMO_EN;
    assign w_in_rmw   = r_state == AMO_RMW;

    assign req_ready_o = ~w_in_rmw & ~(r_s1.valid & w_is_rmw & AMO_EN);
    assign w_accept    = req_valid_i & req_ready_o;

    // Byte-enable merge of store/SC data into the current word
    always_comb begin
        w_merge = w_old;
        for (int i = 0; i < 8; i++) w_merge[8*i+:8] = r_s1.req.be[i] ? r_s1.req.wdata[8*i+:8] : w_old[8*i+:8];
    end

    // The RMW write and an S1 write never coincide: S1 is empty while the FSM is in AMO_RMW
    assign w_we    = w_in_rmw | (r_s1.valid & w_ok & (w_is_store | (w_is_sc & w_hit & AMO_EN)));
    assign w_widx  = w_in_rmw ? r_amo_idx : w_idx;
    assign w_wdata = w_in_rmw ? w_amo_new : w_merge;

    cva6_spm_amo_alu u_alu (
        .i_op      (r_s1.req.op),
        .i_size    (r_s1.req.size),
        .i_be      (r_s1.req.be),
        .i_old     (r_amo_old),
        .i_operand (r_s1.req.wdata),
        .o_new     (w_amo_new)
    );

    // S1 response contents; loads always answer, other ops only when asked
    assign w_s1_rsp = r_s1.valid & ~w_go_rmw & (w_is_load | r_s1.req.need_rsp);
    always_comb begin
        w_rsp         = '0;
        w_rsp.sid     = r_s1.req.sid;
        w_rsp.tid     = r_s1.req.tid;
        w_rsp.aborted = w_abort;
        w_rsp.error   = ~w_abort & (~w_inwin | w_feat_err);
        w_rsp.rdata   = (~w_ok | w_feat_err) ? '0 : w_is_sc ? {63'd0, ~w_hit} : (w_is_load | w_is_lr) ? w_old : '0;
    end

    assign w_unused = ^req_pma_i;

    // S0 -> S1 pipeline register; payload holds while S1 is empty so the RMW cycle can reuse it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s1 <= '0;
        end else begin
            r_s1.valid <= w_accept;
            if (w_accept) r_s1.req <= req_i;
        end
    end

    // AMO FSM and LR/SC reservation
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= IDLE;
            r_amo_idx <= '0;
            r_amo_old <= '0;
            r_resv    <= '0;
        end else begin
            r_state <= w_go_rmw ? AMO_RMW : IDLE;
            if (w_go_rmw) begin
                r_amo_idx <= w_idx;
                r_amo_old <= w_old;
            end
            if (r_s1.valid & w_ok & AMO_EN) begin
                if (w_is_lr) r_resv <= '{valid: 1'b1, granule: w_addr[63:3]};
                else if (w_is_sc | (w_is_store & w_hit)) r_resv.valid <= 1'b0;
            end
        end
    end

    // Response register: S1 results or the old word of a finishing AMO
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rsp_valid <= 1'b0;
            r_rsp       <= '0;
        end else begin
            r_rsp_valid <= w_s1_rsp | (w_in_rmw & r_s1.req.need_rsp);
            if (w_in_rmw) r_rsp <= '{rdata: r_amo_old, sid: r_s1.req.sid, tid: r_s1.req.tid, error: 1'b0, aborted: 1'b0};
            else if (w_s1_rsp) r_rsp <= w_rsp;
        end
    end

    // Storage array, not reset
    always_ff @(posedge clk_i) begin
        if (w_we) r_mem[w_widx] <= w_wdata;
    end

    assign rsp_valid_o = r_rsp_valid;
    assign rsp_o       = r_rsp;

endmodule
